md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy cycles for mult/multu; legal range 1..31.
REQ-002 Parameter DIV_CYCLES, default 10: Busy cycles for div/divu; legal range 1..31.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, ports as below:
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  an EX-stage mult/multu/div/divu is present this cycle.
REQ-007 op  in  2  operation code: 00 mult, 01 multu, 10 div, 11 divu.
REQ-008 D1  in  32  forwarded rs operand.
REQ-009 D2  in  32  forwarded rt operand.
REQ-010 IntReq  in  1  interrupt/exception flush; suppresses a new start and mthi/mtlo.
REQ-011 mthi  in  1  write HI with mt_data.
REQ-012 mtlo  in  1  write LO with mt_data.
REQ-013 mt_data  in  32  data for mthi/mtlo.
REQ-014 md_in_ID  in  1  ID-stage instruction uses HI/LO (mult*, div*, mfhi, mflo, mthi, mtlo).
REQ-015 Busy  out  1  an operation is in progress.
REQ-016 stall  out  1  freeze PC, IF/ID and bubble ID/EX.
REQ-017 done  out  1  one-cycle pulse; HI/LO updated at this edge.
REQ-018 HI  out  32  HI register.
REQ-019 LO  out  32  LO register.

Function
REQ-020 States SHALL be IDLE and RUN; Busy SHALL equal (state==RUN), registered.
REQ-021 In IDLE with start=1 and IntReq=0: SHALL latch op, D1 and D2, load cnt with latency-1, and enter RUN at that edge.
REQ-022 In RUN: cnt!=0 SHALL decrement cnt; cnt==0 SHALL write HI/LO, pulse done, and return to IDLE.
REQ-023 Busy SHALL be high for exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES); new HI/LO SHALL be visible the cycle Busy falls.
REQ-024 start SHALL be ignored while Busy=1; the upstream stall guarantees it does not occur.
REQ-025 stall SHALL equal md_in_ID & (Busy | (start & ~IntReq)), combinational.
REQ-026 IntReq during RUN SHALL NOT abort the operation; the instruction has already committed.
REQ-027 mult: {HI,LO} SHALL be the signed 64-bit product; multu: the unsigned 64-bit product.
REQ-028 div: LO SHALL be the quotient truncated toward zero; HI SHALL be the remainder with the dividend's sign. divu: unsigned quotient and remainder.
REQ-029 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-030 div/divu with D2==0 SHALL leave HI and LO unchanged; done SHALL still pulse.
REQ-031 mthi/mtlo in IDLE with IntReq=0 SHALL write mt_data at the next edge.
REQ-032 mthi/mtlo SHALL be ignored when Busy=1 or IntReq=1.
REQ-033 If start and mthi/mtlo are both asserted, start SHALL take priority.

Reset
REQ-034 Reset=1 at an edge SHALL set state=IDLE, cnt=0, HI=0, LO=0, Busy=0, done=0, latched operands=0.
REQ-035 Reset SHALL override all other inputs, including during RUN; the in-flight operation is discarded with no HI/LO write.

Configuration
REQ-036 Macro MD_FAST_DIV0_EN, when defined: div/divu with D2==0 SHALL load cnt=0, so Busy is high for 1 cycle; HI/LO unchanged.
REQ-037 Without MD_FAST_DIV0_EN: divide-by-zero SHALL take the full DIV_CYCLES; HI/LO unchanged.

Verification
REQ-038 mult D1=0xFFFFFFFE, D2=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses once.
REQ-039 divu D1=7, D2=2 -> Busy high 10 cycles; then LO=3, HI=1. div D1=-7, D2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 start=1 with IntReq=1 -> no RUN; Busy=0; HI/LO unchanged. IntReq pulse at RUN cycle 3 -> operation completes normally.
REQ-041 md_in_ID=1 while Busy -> stall=1 every Busy cycle; stall=0 on the cycle Busy falls. mthi mt_data=0x1234 in IDLE -> HI=0x1234 next cycle.
REQ-042 div D2=0 with HI=0xA, LO=0xB -> HI/LO unchanged; Busy 10 cycles, or 1 with MD_FAST_DIV0_EN. Reset at RUN cycle 2 -> Busy=0, HI=LO=0 next cycle, no done.

Source files
------------

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller owning the HI/LO registers.
// A start in IDLE latches the operands and runs for MULT_CYCLES or DIV_CYCLES;
// the result is written to HI/LO on the edge where Busy falls.
// Optional build macro: MD_FAST_DIV0_EN -- a divide by zero finishes after a
// single busy cycle instead of the full divide latency.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        IntReq,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        md_in_ID,
  output logic        Busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES - 1);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic        done_n;
  logic        accept;
  logic [1:0]  op_p0;
  logic [31:0] d1_p0, d2_p0;
  logic [31:0] hi_n, lo_n;
  logic [63:0] result;
  logic        result_we;

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    logic signed [63:0] ae, be, p;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    p  = ae * be;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
    logic [63:0] ae, be;
    ae = {32'd0, a};
    be = {32'd0, b};
    return ae * be;
  endfunction

  // Signed divide via magnitudes so 0x80000000 / -1 cannot overflow:
  // quotient truncates toward zero, remainder takes the dividend's sign.
  // Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    return {(a[31] ? (32'd0 - r) : r), ((a[31] ^ b[31]) ? (32'd0 - q) : q)};
  endfunction

  // Unsigned divide, returns {remainder, quotient}.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                                input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign Busy  = (state == RUN);
  assign stall = md_in_ID & (Busy | (start & ~IntReq));

  // Result selection from the latched operands; divide by zero never writes.
  always_comb begin
    result    = 64'd0;
    result_we = 1'b1;
    case (op_p0)
      2'b00:   result = mul_signed(d1_p0, d2_p0);
      2'b01:   result = mul_unsigned(d1_p0, d2_p0);
      2'b10:   result = div_signed(d1_p0, d2_p0);
      default: result = div_unsigned(d1_p0, d2_p0);
    endcase
    if (op_p0[1] && (d2_p0 == 32'd0)) begin
      result_we = 1'b0;
    end
  end

  // Next-state, counter, done pulse and HI/LO update decisions.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    accept  = 1'b0;
    hi_n    = HI;
    lo_n    = LO;
    case (state)
      IDLE: begin
        if (start && !IntReq) begin
          accept  = 1'b1;
          state_n = RUN;
          cnt_n   = op[1] ? DIV_LAT : MULT_LAT;
`ifdef MD_FAST_DIV0_EN
          if (op[1] && (D2 == 32'd0)) begin
            cnt_n = 5'd0;
          end
`else
`endif
        end else if (!IntReq) begin
          if (mthi) hi_n = mt_data;
          if (mtlo) lo_n = mt_data;
        end
      end
      RUN: begin
        if (cnt != 5'd0) begin
          cnt_n = cnt - 5'd1;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (result_we) begin
            hi_n = result[63:32];
            lo_n = result[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state register: FSM state, cycle counter and done pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  // Operand capture at the accepting edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_p0 <= 2'b00;
      d1_p0 <= 32'd0;
      d2_p0 <= 32'd0;
    end else if (accept) begin
      op_p0 <= op;
      d1_p0 <= D1;
      d2_p0 <= D2;
    end
  end

  // HI/LO architectural registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else begin
      HI <= hi_n;
      LO <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed tests for md_ctrl with hand-computed expectations.
module tb_md_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] D1 = 32'd0;
  logic [31:0] D2 = 32'd0;
  logic        IntReq = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] mt_data = 32'd0;
  logic        md_in_ID = 1'b0;
  logic        Busy, stall, done;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_fail = 0;

`ifdef MD_FAST_DIV0_EN
  localparam int DIV0_BUSY = 1;
`else
  localparam int DIV0_BUSY = 10;
`endif

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .D1(D1), .D2(D2),
    .IntReq(IntReq), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .md_in_ID(md_in_ID), .Busy(Busy), .stall(stall), .done(done),
    .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Stimulus driver: issue one operation and follow it until Busy falls,
  // optionally pulsing IntReq, Reset or mthi/mtlo at a given busy cycle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int irq_at, input int rst_at, input int mt_at,
                       input logic mt_start,
                       output int nb, output int nd, output int ns,
                       output logic sf, output logic s0);
    @(negedge Clk);
    start = 1'b1; op = o; D1 = a; D2 = b; IntReq = 1'b0;
    mthi = mt_start; mt_data = 32'h0000DEAD;
    #1 s0 = stall;
    @(posedge Clk); #1;
    start = 1'b0; mthi = 1'b0;
    nb = 0; nd = 0; ns = 0;
    while (Busy === 1'b1 && nb < 64) begin
      nb++;
      if (stall === 1'b1) ns++;
      if (nb == irq_at) IntReq = 1'b1;
      if (nb == rst_at) Reset = 1'b1;
      if (nb == mt_at) begin mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hBAD0BAD0; end
      @(posedge Clk); #1;
      IntReq = 1'b0; Reset = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (done === 1'b1) nd++;
    end
    sf = stall;
  endtask

  task automatic test_reset;
    @(negedge Clk);
    Reset = 1'b1; md_in_ID = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", LO); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    Reset = 1'b0; md_in_ID = 1'b0;
  endtask

  task automatic test_mult;
    int nb, nd, ns; logic sf, s0;
    issue(2'b00, 32'hFFFFFFFE, 32'd3, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL mult_done_count: got %0d want 1", nd); end
    n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    n_cmp++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    @(posedge Clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b want 0", done); end
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (HI !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    n_cmp++; if (LO !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL mult_neg_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd1) begin n_fail++; $display("FAIL mult_neg_lo: got %h want 1", LO); end
  endtask

  task automatic test_div;
    int nb, nd, ns; logic sf, s0;
    issue(2'b11, 32'd7, 32'd2, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== 10) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d want 10", nb); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL divu_done_count: got %0d want 1", nd); end
    n_cmp++; if (LO !== 32'd3) begin n_fail++; $display("FAIL divu_lo: got %h want 3", LO); end
    n_cmp++; if (HI !== 32'd1) begin n_fail++; $display("FAIL divu_hi: got %h want 1", HI); end
    issue(2'b10, 32'hFFFFFFF9, 32'd2, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_negdvd_lo: got %h want fffffffd", LO); end
    n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_negdvd_hi: got %h want ffffffff", HI); end
    issue(2'b10, 32'd7, 32'hFFFFFFFE, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_negdvs_lo: got %h want fffffffd", LO); end
    n_cmp++; if (HI !== 32'd1) begin n_fail++; $display("FAIL div_negdvs_hi: got %h want 1", HI); end
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
  endtask

  task automatic test_intreq;
    int nb, nd, ns; logic sf, s0;
    // HI=0, LO=0x80000000 from the previous test
    @(negedge Clk);
    start = 1'b1; op = 2'b00; D1 = 32'd5; D2 = 32'd5; IntReq = 1'b1; md_in_ID = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL irq_start_stall: got %b want 0", stall); end
    @(posedge Clk); #1;
    start = 1'b0; IntReq = 1'b0; md_in_ID = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL irq_start_busy: got %b want 0", Busy); end
    n_cmp++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL irq_start_lo: got %h want 80000000", LO); end
    @(negedge Clk);
    mthi = 1'b1; mt_data = 32'h00000077; IntReq = 1'b1;
    @(posedge Clk); #1;
    mthi = 1'b0; IntReq = 1'b0;
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL irq_mthi: got %h want 0", HI); end
    issue(2'b00, 32'd6, 32'd7, 3, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== 5) begin n_fail++; $display("FAIL irq_run_busy: got %0d want 5", nb); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL irq_run_done: got %0d want 1", nd); end
    n_cmp++; if (LO !== 32'd42) begin n_fail++; $display("FAIL irq_run_lo: got %h want 2a", LO); end
  endtask

  task automatic test_stall;
    int nb, nd, ns; logic sf, s0;
    md_in_ID = 1'b1;
    issue(2'b00, 32'd2, 32'd3, -1, -1, 2, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b want 1", s0); end
    n_cmp++; if (ns !== 5) begin n_fail++; $display("FAIL stall_busy_cycles: got %0d want 5", ns); end
    n_cmp++; if (sf !== 1'b0) begin n_fail++; $display("FAIL stall_at_fall: got %b want 0", sf); end
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL busy_mthi_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd6) begin n_fail++; $display("FAIL busy_mtlo_lo: got %h want 6", LO); end
    md_in_ID = 1'b0;
  endtask

  task automatic test_mt;
    int nb, nd, ns; logic sf, s0;
    @(negedge Clk);
    mthi = 1'b1; mt_data = 32'h00001234;
    @(posedge Clk); #1;
    mthi = 1'b0;
    n_cmp++; if (HI !== 32'h00001234) begin n_fail++; $display("FAIL mthi: got %h want 1234", HI); end
    @(negedge Clk);
    mtlo = 1'b1; mt_data = 32'h00005678;
    @(posedge Clk); #1;
    mtlo = 1'b0;
    n_cmp++; if (LO !== 32'h00005678) begin n_fail++; $display("FAIL mtlo: got %h want 5678", LO); end
    n_cmp++; if (HI !== 32'h00001234) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h want 1234", HI); end
    issue(2'b01, 32'd3, 32'd5, -1, -1, -1, 1'b1, nb, nd, ns, sf, s0);
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL start_prio_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd15) begin n_fail++; $display("FAIL start_prio_lo: got %h want f", LO); end
  endtask

  task automatic test_div0;
    int nb, nd, ns; logic sf, s0;
    @(negedge Clk);
    mthi = 1'b1; mtlo = 1'b0; mt_data = 32'h0000000A;
    @(negedge Clk);
    mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h0000000B;
    @(negedge Clk);
    mtlo = 1'b0;
    issue(2'b10, 32'd5, 32'd0, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== DIV0_BUSY) begin n_fail++; $display("FAIL div0_busy: got %0d want %0d", nb, DIV0_BUSY); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL div0_done: got %0d want 1", nd); end
    n_cmp++; if (HI !== 32'h0000000A) begin n_fail++; $display("FAIL div0_hi: got %h want a", HI); end
    n_cmp++; if (LO !== 32'h0000000B) begin n_fail++; $display("FAIL div0_lo: got %h want b", LO); end
    issue(2'b11, 32'd9, 32'd0, -1, -1, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== DIV0_BUSY) begin n_fail++; $display("FAIL divu0_busy: got %0d want %0d", nb, DIV0_BUSY); end
    n_cmp++; if (LO !== 32'h0000000B) begin n_fail++; $display("FAIL divu0_lo: got %h want b", LO); end
  endtask

  task automatic test_reset_run;
    int nb, nd, ns; logic sf, s0;
    issue(2'b00, 32'hFFFFFFFE, 32'd3, -1, 2, -1, 1'b0, nb, nd, ns, sf, s0);
    n_cmp++; if (nb !== 2) begin n_fail++; $display("FAIL rst_run_busy: got %0d want 2", nb); end
    n_cmp++; if (nd !== 0) begin n_fail++; $display("FAIL rst_run_done: got %0d want 0", nd); end
    n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_run_busy_low: got %b want 0", Busy); end
    n_cmp++; if (HI !== 32'd0) begin n_fail++; $display("FAIL rst_run_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_fail++; $display("FAIL rst_run_lo: got %h want 0", LO); end
    repeat (6) @(posedge Clk);
    #1;
    n_cmp++; if (HI !== 32'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_no_late_write: got hi=%h done=%b want 0/0", HI, done);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_intreq;
    test_stall;
    test_mt;
    test_div0;
    test_reset_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
